legv8_control_unit: RTL and testbench
=====================================

Name: legv8_control_unit

Overview:
- Multi-cycle control sequencer that drives the LEGv8 datapath.
- Fetches 32-bit instructions over a req/ack handshake and decodes a fixed subset.
- Issues the 25-bit ControlWord and 64-bit constant each cycle, consumes the datapath's 4-bit ALU status, and owns the PC and the condition-flag register.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  32  instruction word from instruction memory.
- imem_ack  in  1  instruction valid; sampled only in FETCH.
- status  in  4  datapath ALU status {V,C,N,Z}; Z is bit 0.
- imem_req  out  1  fetch request.
- pc  out  64  current instruction address.
- ControlWord  out  25  datapath control word (packing under Behaviour).
- constant  out  64  extended immediate.
- flags  out  4  latched {V,C,N,Z}.
- halted  out  1  unsupported opcode seen.

Behaviour:
- ControlWord packing: [24:20] SA, [19:15] SB, [14:10] DA, [9] RegWrite, [8:4] FS, [3] Bsel, [2] MemWrite, [1] EN_Mem, [0] EN_ALU.
- FS codes: ADD 01000, SUB 01011, AND 00000, ORR 00100. FS[0] is the ALU carry-in.
- Register fields: Rd/Rt = IR[4:0], Rn = IR[9:5], Rm = IR[20:16]. Register 31 reads as zero.
- Reset (async, reset low): state=FETCH, pc=RESET_PC, flags=0, halted=0, IR=0. ControlWord=0, constant=0 and imem_req=0 while reset is low.
- State FETCH:
  - imem_req=1, ControlWord=0.
  - On imem_ack=1: latch IR and go to DECODE. Otherwise stay (no timeout).
- State DECODE: one cycle, ControlWord=0, imem_req=0. Selects EXEC or HALT.
- State EXEC, R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDS 10101011000, SUBS 11101011000):
  - SA=Rn, SB=Rm, DA=Rd, RegWrite=1, EN_ALU=1, Bsel=0.
  - ADDS/SUBS also latch status into flags at the end of EXEC.
  - pc+=4, then FETCH.
- State EXEC, I-type (ADDI 1001000100, SUBI 1101000100):
  - constant = zero-extended IR[21:10], Bsel=1. Otherwise as R-type.
- LDUR (11111000010):
  - EXEC: SA=Rn, Bsel=1, FS=ADD, constant = sign-extended IR[20:12], no enables. Go to MEM.
  - MEM: same SA/Bsel/FS/constant, plus DA=Rt, RegWrite=1, EN_Mem=1. pc+=4, then FETCH.
- STUR (11111000000), EXEC only: SA=Rn, SB=Rt, Bsel=1, FS=ADD, constant = sign-extended IR[20:12], MemWrite=1, RegWrite=0. pc+=4.
- CBZ (IR[31:24]=10110100), EXEC:
  - SA=31, SB=Rt, Bsel=0, FS=ADD, no writes.
  - status[0]=1: pc += sext(IR[23:5])<<2. Else pc+=4.
- B.cond (IR[31:24]=01010100), EXEC, ControlWord=0. Test on latched flags with cond=IR[3:0]:
  - Supported: EQ 0000 (Z), NE 0001 (!Z), GE 1010 (N==V), LT 1011 (N!=V), AL 1110 (always).
  - Taken: pc += sext(IR[23:5])<<2. Other cond values are not taken: pc+=4.
- B (IR[31:26]=000101), EXEC: pc += sext(IR[25:0])<<2, ControlWord=0.
- PC arithmetic is modulo 2^64; wrap is silent.
- Any other opcode: DECODE goes to HALT. HALT sets halted=1, holds ControlWord=0 and imem_req=0, holds pc, and leaves only on reset.
- Outputs are registered-state decoded (Moore). ControlWord is stable for the whole state, so register and memory writes occur at the closing clock edge.
- flags change only on ADDS/SUBS. A reset assertion mid-instruction aborts it with no partial writes beyond edges already taken.

Test Plan:
- Reset low mid-EXEC with RegWrite high -> ControlWord=0, pc=0, imem_req=0 immediately (asynchronous); after release, imem_req=1 in FETCH.
- Hold imem_ack=0 for 5 cycles in FETCH -> state holds, imem_req stays 1, ControlWord=0; ack with ADD X3,X1,X2 -> EXEC ControlWord=0x110E81, pc 0->4.
- LDUR X5,[X2,#-8] -> EXEC constant=64'hFFFF_FFFF_FFFF_FFF8, no enables; MEM RegWrite=1, EN_Mem=1, DA=5; pc+=4 after 4 cycles total.
- CBZ X7,#+3 at pc=0x10 with status[0]=1 -> pc=0x1C. With status[0]=0 -> pc=0x14.
- SUBS with status=4'b1000 (V=1,N=0), then B.LT #-2 at pc=0x20 -> flags=1000, branch taken, pc=0x18. B.EQ from the same state -> pc+=4.
- Instruction 32'h0000_0000 -> halted=1 after DECODE; imem_ack pulses ignored; pc frozen until reset.

Source files
------------

// File: rtl/legv8_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : legv8_control_unit
//  Description : Multi-cycle control sequencer for the LEGv8 datapath.
//                Fetches instructions over a req/ack handshake, decodes a
//                fixed subset (R-type ALU ops, ADDI/SUBI, LDUR/STUR, CBZ,
//                B.cond, B) and drives a 25-bit ControlWord plus a 64-bit
//                constant every cycle. Owns the PC and the {V,C,N,Z} flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1   system clock, rising edge
//    reset        in   1   asynchronous, active-low reset
//    instruction  in  32   instruction word from instruction memory
//    imem_ack     in   1   instruction valid, sampled only in FETCH
//    status       in   4   datapath ALU status {V,C,N,Z}
//    imem_req     out  1   fetch request
//    pc           out 64   current instruction address
//    ControlWord  out 25   {SA,SB,DA,RegWrite,FS,Bsel,MemWrite,EN_Mem,EN_ALU}
//    constant     out 64   extended immediate
//    flags        out  4   latched {V,C,N,Z}
//    halted       out  1   unsupported opcode seen
// ============================================================================
module legv8_control_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        imem_ack,
    input  logic [3:0]  status,
    output logic        imem_req,
    output logic [63:0] pc,
    output logic [24:0] ControlWord,
    output logic [63:0] constant,
    output logic [3:0]  flags,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [10:0] C_OP_ADD   = 11'b10001011000;
    localparam logic [10:0] C_OP_SUB   = 11'b11001011000;
    localparam logic [10:0] C_OP_AND   = 11'b10001010000;
    localparam logic [10:0] C_OP_ORR   = 11'b10101010000;
    localparam logic [10:0] C_OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] C_OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] C_OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] C_OP_STUR  = 11'b11111000000;
    localparam logic [9:0]  C_OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  C_OP_SUBI  = 10'b1101000100;
    localparam logic [7:0]  C_OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  C_OP_BCOND = 8'b01010100;
    localparam logic [5:0]  C_OP_B     = 6'b000101;

    localparam logic [4:0]  C_FS_ADD   = 5'b01000;
    localparam logic [4:0]  C_FS_SUB   = 5'b01011;
    localparam logic [4:0]  C_FS_AND   = 5'b00000;
    localparam logic [4:0]  C_FS_ORR   = 5'b00100;

    state_t      r_state;
    state_t      w_next_state;
    logic [63:0] r_pc;
    logic [63:0] w_next_pc;
    logic [31:0] r_ir;
    logic [3:0]  r_flags;
    logic        w_flag_we;

    // ------------------------------------------------------------------
    // Instruction field extraction and classification
    // ------------------------------------------------------------------
    logic [10:0] w_op11;
    logic [9:0]  w_op10;
    logic [7:0]  w_op8;
    logic [5:0]  w_op6;
    logic [4:0]  w_rd;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic [63:0] w_i_imm;
    logic [63:0] w_d_imm;
    logic [63:0] w_cond_off;
    logic [63:0] w_b_off;
    logic        w_is_rtype;
    logic        w_is_itype;
    logic        w_is_ldur;
    logic        w_is_stur;
    logic        w_is_cbz;
    logic        w_is_bcond;
    logic        w_is_b;
    logic        w_is_setflags;
    logic        w_supported;
    logic        w_cond_taken;
    logic [4:0]  w_alu_fs;

    assign w_op11 = r_ir[31:21];
    assign w_op10 = r_ir[31:22];
    assign w_op8  = r_ir[31:24];
    assign w_op6  = r_ir[31:26];
    assign w_rd   = r_ir[4:0];
    assign w_rn   = r_ir[9:5];
    assign w_rm   = r_ir[20:16];

    assign w_i_imm    = {52'd0, r_ir[21:10]};
    assign w_d_imm    = {{55{r_ir[20]}}, r_ir[20:12]};
    // Branch offsets are word counts; shift left by two for byte addresses.
    assign w_cond_off = {{43{r_ir[23]}}, r_ir[23:5], 2'b00};
    assign w_b_off    = {{36{r_ir[25]}}, r_ir[25:0], 2'b00};

    assign w_is_rtype = (w_op11 == C_OP_ADD)  || (w_op11 == C_OP_SUB)  ||
                        (w_op11 == C_OP_AND)  || (w_op11 == C_OP_ORR)  ||
                        (w_op11 == C_OP_ADDS) || (w_op11 == C_OP_SUBS);
    assign w_is_itype = (w_op10 == C_OP_ADDI) || (w_op10 == C_OP_SUBI);
    assign w_is_ldur  = (w_op11 == C_OP_LDUR);
    assign w_is_stur  = (w_op11 == C_OP_STUR);
    assign w_is_cbz   = (w_op8  == C_OP_CBZ);
    assign w_is_bcond = (w_op8  == C_OP_BCOND);
    assign w_is_b     = (w_op6  == C_OP_B);

    assign w_is_setflags = (w_op11 == C_OP_ADDS) || (w_op11 == C_OP_SUBS);
    assign w_supported   = w_is_rtype || w_is_itype || w_is_ldur || w_is_stur ||
                           w_is_cbz   || w_is_bcond || w_is_b;

    // ALU function for the arithmetic/logic instruction groups
    always_comb begin
        w_alu_fs = C_FS_ADD;
        if (w_is_itype) begin
            w_alu_fs = (w_op10 == C_OP_SUBI) ? C_FS_SUB : C_FS_ADD;
        end else begin
            case (w_op11)
                C_OP_SUB, C_OP_SUBS: w_alu_fs = C_FS_SUB;
                C_OP_AND:            w_alu_fs = C_FS_AND;
                C_OP_ORR:            w_alu_fs = C_FS_ORR;
                default:             w_alu_fs = C_FS_ADD;
            endcase
        end
    end

    // Conditional-branch test against the latched flags {V,C,N,Z}
    always_comb begin
        case (r_ir[3:0])
            4'b0000: w_cond_taken = r_flags[0];
            4'b0001: w_cond_taken = ~r_flags[0];
            4'b1010: w_cond_taken = (r_flags[1] == r_flags[3]);
            4'b1011: w_cond_taken = (r_flags[1] != r_flags[3]);
            4'b1110: w_cond_taken = 1'b1;
            default: w_cond_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    logic [4:0]  w_sa;
    logic [4:0]  w_sb;
    logic [4:0]  w_da;
    logic        w_regwrite;
    logic [4:0]  w_fs;
    logic        w_bsel;
    logic        w_memwrite;
    logic        w_en_mem;
    logic        w_en_alu;
    logic [63:0] w_constant;
    logic        w_req;
    logic [24:0] w_cw;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_flag_we    = 1'b0;
        w_sa         = 5'd0;
        w_sb         = 5'd0;
        w_da         = 5'd0;
        w_regwrite   = 1'b0;
        w_fs         = 5'd0;
        w_bsel       = 1'b0;
        w_memwrite   = 1'b0;
        w_en_mem     = 1'b0;
        w_en_alu     = 1'b0;
        w_constant   = 64'd0;
        w_req        = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                w_next_state = w_supported ? S_EXEC : S_HALT;
            end

            S_EXEC: begin
                w_next_state = S_FETCH;
                w_next_pc    = r_pc + 64'd4;
                if (w_is_rtype || w_is_itype) begin
                    w_sa       = w_rn;
                    w_sb       = w_rm;
                    w_da       = w_rd;
                    w_regwrite = 1'b1;
                    w_en_alu   = 1'b1;
                    w_fs       = w_alu_fs;
                    w_bsel     = w_is_itype;
                    w_constant = w_is_itype ? w_i_imm : 64'd0;
                    w_flag_we  = w_is_setflags;
                end else if (w_is_ldur) begin
                    // Address phase only; the load writes back in MEM.
                    w_sa         = w_rn;
                    w_bsel       = 1'b1;
                    w_fs         = C_FS_ADD;
                    w_constant   = w_d_imm;
                    w_next_pc    = r_pc;
                    w_next_state = S_MEM;
                end else if (w_is_stur) begin
                    w_sa       = w_rn;
                    w_sb       = w_rd;
                    w_bsel     = 1'b1;
                    w_fs       = C_FS_ADD;
                    w_constant = w_d_imm;
                    w_memwrite = 1'b1;
                end else if (w_is_cbz) begin
                    // Rt + XZR through the ALU so Z reflects Rt == 0.
                    w_sa = 5'd31;
                    w_sb = w_rd;
                    w_fs = C_FS_ADD;
                    if (status[0]) begin
                        w_next_pc = r_pc + w_cond_off;
                    end
                end else if (w_is_bcond) begin
                    if (w_cond_taken) begin
                        w_next_pc = r_pc + w_cond_off;
                    end
                end else if (w_is_b) begin
                    w_next_pc = r_pc + w_b_off;
                end else begin
                    // Unreachable: DECODE filters unsupported opcodes.
                    w_next_pc    = r_pc;
                    w_next_state = S_HALT;
                end
            end

            S_MEM: begin
                w_sa         = w_rn;
                w_bsel       = 1'b1;
                w_fs         = C_FS_ADD;
                w_constant   = w_d_imm;
                w_da         = w_rd;
                w_regwrite   = 1'b1;
                w_en_mem     = 1'b1;
                w_next_pc    = r_pc + 64'd4;
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign w_cw = {w_sa, w_sb, w_da, w_regwrite, w_fs,
                   w_bsel, w_memwrite, w_en_mem, w_en_alu};

    // ------------------------------------------------------------------
    // State, PC, IR and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 32'd0;
            r_flags <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if ((r_state == S_FETCH) && imem_ack) begin
                r_ir <= instruction;
            end
            if (w_flag_we) begin
                r_flags <= status;
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign imem_req    = w_req & reset;
    assign ControlWord = reset ? w_cw : 25'd0;
    assign constant    = reset ? w_constant : 64'd0;
    assign pc          = r_pc;
    assign flags       = r_flags;
    assign halted      = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_legv8_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_legv8_control_unit
//  Description : Scoreboard testbench for legv8_control_unit. The stimulus
//                process drives directed instruction sequences and queues the
//                expected per-cycle outputs; the monitor process pops and
//                compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_legv8_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        imem_ack = 1'b0;
    logic [3:0]  status = 4'd0;
    logic        imem_req;
    logic [63:0] pc;
    logic [24:0] ControlWord;
    logic [63:0] constant;
    logic [3:0]  flags;
    logic        halted;

    legv8_control_unit #(
        .RESET_PC(64'h0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .instruction(instruction),
        .imem_ack   (imem_ack),
        .status     (status),
        .imem_req   (imem_req),
        .pc         (pc),
        .ControlWord(ControlWord),
        .constant   (constant),
        .flags      (flags),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        req;
        logic [24:0] cw;
        logic [24:0] cwm;
        logic        kc;
        logic [63:0] k;
        logic [63:0] pc;
        logic [3:0]  fl;
        logic        hl;
    } exp_t;

    localparam logic [24:0] FULL = 25'h1FFFFFF;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  probe = 1'b0;
    logic [63:0] m_pc = 64'd0;
    logic [3:0]  m_fl = 4'd0;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_i(logic [9:0] op, logic [11:0] imm, logic [4:0] rn, logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(logic [7:0] op, logic [18:0] imm, logic [4:0] rt);
        return {op, imm, rt};
    endfunction

    // ---------------- scoreboard push / stimulus ----------------
    task automatic push(input string nm, input logic req, input logic [24:0] cw, input logic [24:0] cwm,
                        input logic kc, input logic [63:0] k, input logic hl);
        exp_t e;
        e.req = req; e.cw = cw; e.cwm = cwm; e.kc = kc; e.k = k;
        e.pc = m_pc; e.fl = m_fl; e.hl = hl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input string nm, input logic ack, input logic [31:0] ins, input logic [3:0] st,
                        input logic req, input logic [24:0] cw, input logic [24:0] cwm,
                        input logic kc, input logic [63:0] k, input logic hl);
        imem_ack    = ack;
        instruction = ins;
        status      = st;
        push(nm, req, cw, cwm, kc, k, hl);
        @(posedge clock);
        #1;
    endtask

    // FETCH (acked), DECODE, EXEC; then update the model PC/flags.
    task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] st,
                       input logic [24:0] cw, input logic [24:0] cwm, input logic kc, input logic [63:0] k,
                       input logic [63:0] npc, input logic [3:0] nfl);
        step({nm, "_fetch"},  1'b1, ins,   4'd0, 1'b1, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        step({nm, "_decode"}, 1'b0, 32'd0, 4'd0, 1'b0, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        step({nm, "_exec"},   1'b0, 32'd0, st,   1'b0, cw,    cwm,  kc,   k,     1'b0);
        m_pc = npc;
        m_fl = nfl;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock or posedge probe) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (imem_req !== e.req || ((ControlWord ^ e.cw) & e.cwm) !== 25'd0 ||
                (e.kc && constant !== e.k) || pc !== e.pc || flags !== e.fl || halted !== e.hl) begin
                errors++;
                $display("FAIL %s: got req=%b cw=%h k=%h pc=%h flags=%b halted=%b; want req=%b cw=%h (mask %h) k=%h (chk %b) pc=%h flags=%b halted=%b",
                         nm, imem_req, ControlWord, constant, pc, flags, halted,
                         e.req, e.cw, e.cwm, e.k, e.kc, e.pc, e.fl, e.hl);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] i_add;
        logic [31:0] i_ldur;
        i_add  = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3);
        i_ldur = enc_d(11'b11111000010, 9'h1F8, 5'd2, 5'd5);

        @(posedge clock);
        #1;
        step("reset_state", 1'b0, 32'd0, 4'd0, 1'b0, 25'd0, FULL, 1'b1, 64'd0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++)
            step("fetch_stall", 1'b0, i_add, 4'd0, 1'b1, 25'd0, FULL, 1'b0, 64'd0, 1'b0);

        run("add", i_add, 4'b0110, 25'h110E81, FULL, 1'b0, 64'd0, 64'h4, 4'b0000);

        // LDUR X5,[X2,#-8]: FETCH, DECODE, EXEC, MEM
        step("ldur_fetch",  1'b1, i_ldur, 4'd0, 1'b1, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        step("ldur_decode", 1'b0, 32'd0,  4'd0, 1'b0, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        step("ldur_exec",   1'b0, 32'd0,  4'b1111, 1'b0, 25'h200088, 25'h1F003FF, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        step("ldur_mem",    1'b0, 32'd0,  4'b1111, 1'b0, 25'h20168A, 25'h1F07FFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        m_pc = 64'h8;

        run("addi", enc_i(10'b1001000100, 12'hABC, 5'd31, 5'd4), 4'b0011,
            25'h1F01289, 25'h1F07FFF, 1'b1, 64'hABC, 64'hC, 4'b0000);
        run("subi", enc_i(10'b1101000100, 12'h001, 5'd4, 5'd6), 4'b1001,
            25'h401AB9, 25'h1F07FFF, 1'b1, 64'h1, 64'h10, 4'b0000);
        run("cbz_taken", enc_cb(8'b10110100, 19'd3, 5'd7), 4'b0001,
            25'h1F38080, 25'h1FF83FC, 1'b0, 64'd0, 64'h1C, 4'b0000);
        run("b_back", {6'b000101, 26'h3FFFFFD}, 4'b1111,
            25'd0, FULL, 1'b0, 64'd0, 64'h10, 4'b0000);
        run("cbz_not", enc_cb(8'b10110100, 19'd3, 5'd7), 4'b1110,
            25'h1F38080, 25'h1FF83FC, 1'b0, 64'd0, 64'h14, 4'b0000);
        run("subs", enc_r(11'b11101011000, 5'd2, 5'd1, 5'd9), 4'b1000,
            25'h1126B1, FULL, 1'b0, 64'd0, 64'h18, 4'b1000);
        run("b_eq", enc_cb(8'b01010100, 19'd5, 5'b00000), 4'b0001,
            25'd0, FULL, 1'b0, 64'd0, 64'h1C, 4'b1000);
        run("add_noflag", i_add, 4'b0101, 25'h110E81, FULL, 1'b0, 64'd0, 64'h20, 4'b1000);
        run("b_lt", enc_cb(8'b01010100, 19'h7FFFE, 5'b01011), 4'b0000,
            25'd0, FULL, 1'b0, 64'd0, 64'h18, 4'b1000);

        // Unsupported opcode at 0x18: HALT, ack pulses ignored
        step("halt_fetch",  1'b1, 32'd0, 4'd0, 1'b1, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        step("halt_decode", 1'b0, 32'd0, 4'd0, 1'b0, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            step("halt_hold", ~i[0], i_add, 4'b1111, 1'b0, 25'd0, FULL, 1'b0, 64'd0, 1'b1);

        // Reset leaves HALT
        reset = 1'b0;
        m_pc  = 64'd0;
        m_fl  = 4'd0;
        step("reset_in_halt", 1'b0, 32'd0, 4'd0, 1'b0, 25'd0, FULL, 1'b1, 64'd0, 1'b0);
        reset = 1'b1;

        run("stur", enc_d(11'b11111000000, 9'd16, 5'd3, 5'd8), 4'b1111,
            25'h34008C, 25'h1FF83FF, 1'b1, 64'd16, 64'h4, 4'b0000);

        // Reset asserted in the middle of an ADD EXEC cycle
        step("mid_fetch",  1'b1, i_add, 4'd0, 1'b1, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        step("mid_decode", 1'b0, 32'd0, 4'd0, 1'b0, 25'd0, FULL, 1'b0, 64'd0, 1'b0);
        imem_ack = 1'b0;
        status   = 4'b1111;
        push("mid_exec", 1'b0, 25'h110E81, FULL, 1'b0, 64'd0, 1'b0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        m_pc  = 64'd0;
        m_fl  = 4'd0;
        push("async_reset", 1'b0, 25'd0, FULL, 1'b1, 64'd0, 1'b0);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step("post_reset_fetch", 1'b0, 32'd0, 4'd0, 1'b1, 25'd0, FULL, 1'b0, 64'd0, 1'b0);

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
